// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
// Purpose: FSM state encoding and default operand width used by serial_adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - one-bit combinational full-adder cell
// Purpose: single full-adder stage used once per clock by serial_adder.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out (majority of a, b, cin)
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one result bit per clock, LSB first
// Purpose: adds two WIDTH-bit operands through a single full-adder cell over
//   WIDTH RUN cycles, then pulses done for one cycle.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port; sub=1 at
//   acceptance computes a-b (cout=1 means no borrow, i.e. a>=b).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   sub    - (SERIAL_ADDER_SUB_EN only) select subtraction at acceptance
//   start  - begin an operation; accepted only in IDLE
//   a, b   - operands, sampled only on an accepted start
//   busy   - high in RUN and DONE
//   done   - one-cycle pulse, result valid
//   sum    - result bits, held until the next accepted start
//   cout   - final carry (add) / no-borrow flag (sub)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;
  logic             load;
  logic             shift;

  fa u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        shift = 1'b1;
        // cnt counts completed bits; this edge processes the last one
        if (cnt == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      sh_a <= a;
      cnt  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      // a - b = a + ~b + 1: invert b and seed the carry
      sh_b  <= sub ? ~b : b;
      carry <= sub;
`else
      sh_b  <= b;
      carry <= 1'b0;
`endif
    end else if (shift) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      sum   <= {bit_s, sum[WIDTH-1:1]};
      carry <= bit_c;
      cnt   <= cnt + CW'(1);
    end
  end

  // carry holds its final value after RUN until the next load
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  logic fa_a, fa_b, fa_cin, fa_s, fa_cout;

  int vectors = 0;
  int errors  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  fa u_fa_chk (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .s    (fa_s),
    .cout (fa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is 1ns after a rising edge with the DUT in IDLE.
  task automatic op(input logic [7:0] av, input logic [7:0] bv,
                    input logic [7:0] es, input logic ec, input string tag);
    a = av;
    b = bv;
    start = 1'b1;
    tick();                          // E0
    start = 1'b0;
    a = ~av;                         // post-acceptance changes must be ignored
    b = ~bv;
    chk({tag, "_busy_e0"}, busy, 1);
    repeat (WIDTH - 1) tick();       // E0+7
    chk({tag, "_nodone_e7"}, done, 0);
    tick();                          // E0+8
    chk({tag, "_done_e8"}, done, 1);
    chk({tag, "_busy_e8"}, busy, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    tick();                          // E0+9
    chk({tag, "_busy_e9"}, busy, 0);
    chk({tag, "_done_e9"}, done, 0);
    chk({tag, "_sum_hold"}, sum, es);
    chk({tag, "_cout_hold"}, cout, ec);
  endtask

  initial begin
    int seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_cin = 1'b0;

    // reset state
    tick();
    start = 1'b1;                    // must not be accepted while in reset
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    op(8'h00, 8'h00, 8'h00, 1'b0, "zero");
    op(8'hFF, 8'h01, 8'h00, 1'b1, "ripple");

    // 0x5A+0x3C with a stray start at E0+3, then back-to-back 0x11+0x22
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    tick();                          // E0
    start = 1'b0;
    tick();
    tick();                          // E0+2
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    tick();                          // E0+3 (ignored)
    start = 1'b0;
    chk("stray_busy", busy, 1);
    repeat (4) tick();               // E0+7
    chk("stray_nodone_e7", done, 0);
    tick();                          // E0+8
    chk("stray_done_e8", done, 1);
    chk("stray_sum", sum, 8'h96);
    chk("stray_cout", cout, 0);
    tick();                          // E0+9
    chk("stray_idle_e9", busy, 0);
    op(8'h11, 8'h22, 8'h33, 1'b0, "b2b");
    tick();
    tick();
    chk("b2b_no_extra_busy", busy, 0);

    op(8'h80, 8'h80, 8'h00, 1'b1, "msb_carry");
    op(8'hC3, 8'h5E, 8'h21, 1'b1, "mixed");

    // reset mid-operation
    a = 8'hAB;
    b = 8'h12;
    start = 1'b1;
    tick();                          // E0
    start = 1'b0;
    repeat (4) tick();               // E0+4
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    chk("midrst_no_done", seen_done, 0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    op(8'h10, 8'h20, 8'hF0, 1'b0, "sub_neg");
    op(8'h20, 8'h10, 8'h10, 1'b1, "sub_pos");
    op(8'h33, 8'h33, 8'h00, 1'b1, "sub_eq");
    sub = 1'b0;
    op(8'h10, 8'h20, 8'h30, 1'b0, "add_in_sub_build");
`endif

    // full-adder cell, all 8 input combinations
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] cnt1;
      v = 3'(i);
      fa_a = v[2];
      fa_b = v[1];
      fa_cin = v[0];
      cnt1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      #1;
      chk($sformatf("fa_%0d", i), {30'd0, fa_cout, fa_s}, {30'd0, cnt1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
